// File: rtl/md5_step_sched.sv
// MD5 compression step sequencer: accepts a block, walks steps 0..63 with g/s/f decode, then feed-forward and digest handshake.
// Optional datapath back-pressure is enabled by defining MD5_STALL_EN (adds the dp_ready_i port).
module md5_step_sched #(
   parameter int FF_LAT     = 1,
   parameter bit KEEP_CHAIN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       blk_valid_i,
   input  logic       first_i,
   output logic       blk_ready_o,
   input  logic       abort_i,
   output logic       load_o,
   output logic       iv_sel_o,
   output logic       step_en_o,
   output logic [5:0] step_o,
   output logic [3:0] g_o,
   output logic [4:0] s_o,
   output logic [1:0] fsel_o,
   output logic       ff_add_o,
   output logic       hash_valid_o,
   input  logic       hash_ready_i
`ifdef MD5_STALL_EN
   ,
   input  logic       dp_ready_i
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, FF, DONE} state_t;

   state_t     state, state_nxt;
   logic [5:0] step;
   logic [1:0] ff_cnt;
   logic       first_q;
   logic       step_adv;
   logic       dp_ok;
   logic [3:0] idx;
   logic [1:0] rnd;

`ifdef MD5_STALL_EN
   assign dp_ok = dp_ready_i;
`else
   assign dp_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-state strobes; abort from any busy state returns to IDLE
   always_comb begin
      state_nxt    = state;
      blk_ready_o  = 1'b0;
      load_o       = 1'b0;
      step_en_o    = 1'b0;
      step_adv     = 1'b0;
      ff_add_o     = 1'b0;
      hash_valid_o = 1'b0;
      case (state)
         IDLE: begin
            blk_ready_o = 1'b1;
            if (blk_valid_i) state_nxt = LOAD;
         end
         LOAD: begin
            load_o    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            step_en_o = dp_ok;
            step_adv  = dp_ok;
            if (dp_ok && step == 6'd63) state_nxt = FF;
         end
         FF: begin
            ff_add_o = (ff_cnt == 2'd0) && !abort_i;
            if (ff_cnt == 2'(FF_LAT - 1)) state_nxt = DONE;
         end
         DONE: begin
            hash_valid_o = 1'b1;
            if (hash_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_i && state != IDLE) state_nxt = IDLE;
   end

   // Step counter wraps 63->0 naturally on the last advance, which is the RUN->FF exit
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         step    <= 6'd0;
         ff_cnt  <= 2'd0;
         first_q <= 1'b1;
      end else begin
         if (state == IDLE && blk_valid_i) first_q <= first_i;
         if (load_o)        step <= 6'd0;
         else if (step_adv) step <= step + 6'd1;
         ff_cnt <= (state == FF) ? ff_cnt + 2'd1 : 2'd0;
      end
   end

   assign iv_sel_o = first_q | ~KEEP_CHAIN;
   assign step_o   = step;
   assign idx      = step[3:0];
   assign rnd      = step[5:4];
   assign fsel_o   = rnd;

   // Message index as shift-and-add in 4 bits so the mod 16 is free
   always_comb begin
      g_o = idx;
      case (rnd)
         2'd0: g_o = idx;
         2'd1: g_o = {idx[1:0], 2'b00} + idx + 4'd1;
         2'd2: g_o = {idx[2:0], 1'b0} + idx + 4'd5;
         2'd3: g_o = {idx[0], 3'b000} - idx;
         default: g_o = idx;
      endcase
   end

   always_comb begin
      s_o = 5'd0;
      case ({rnd, idx[1:0]})
         4'h0: s_o = 5'd7;   4'h1: s_o = 5'd12;  4'h2: s_o = 5'd17;  4'h3: s_o = 5'd22;
         4'h4: s_o = 5'd5;   4'h5: s_o = 5'd9;   4'h6: s_o = 5'd14;  4'h7: s_o = 5'd20;
         4'h8: s_o = 5'd4;   4'h9: s_o = 5'd11;  4'hA: s_o = 5'd16;  4'hB: s_o = 5'd23;
         4'hC: s_o = 5'd6;   4'hD: s_o = 5'd10;  4'hE: s_o = 5'd15;  4'hF: s_o = 5'd21;
         default: s_o = 5'd0;
      endcase
   end

endmodule

// File: tb/tb_md5_step_sched.sv
// Directed bench for md5_step_sched: timing, decode, chaining, abort, async reset (and stall with MD5_STALL_EN).
module tb_md5_step_sched;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       blk_valid_i = 1'b0, first_i = 1'b0, abort_i = 1'b0, hash_ready_i = 1'b0;
   logic       blk_ready_o, load_o, iv_sel_o, step_en_o, ff_add_o, hash_valid_o;
   logic [5:0] step_o;
   logic [3:0] g_o;
   logic [4:0] s_o;
   logic [1:0] fsel_o;
   logic       nc_blk_ready, nc_load, nc_iv_sel, nc_step_en, nc_ff_add, nc_hash_valid;
   logic [5:0] nc_step;
   logic [3:0] nc_g;
   logic [4:0] nc_s;
   logic [1:0] nc_fsel;
`ifdef MD5_STALL_EN
   logic       dp_ready_i = 1'b1;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   md5_step_sched #(.FF_LAT(1), .KEEP_CHAIN(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .blk_valid_i(blk_valid_i), .first_i(first_i),
      .blk_ready_o(blk_ready_o), .abort_i(abort_i), .load_o(load_o), .iv_sel_o(iv_sel_o),
      .step_en_o(step_en_o), .step_o(step_o), .g_o(g_o), .s_o(s_o), .fsel_o(fsel_o),
      .ff_add_o(ff_add_o), .hash_valid_o(hash_valid_o), .hash_ready_i(hash_ready_i)
`ifdef MD5_STALL_EN
      , .dp_ready_i(dp_ready_i)
`endif
   );

   md5_step_sched #(.FF_LAT(1), .KEEP_CHAIN(1'b0)) dut_nc (
      .clk_i(clk_i), .rst_i(rst_i), .blk_valid_i(blk_valid_i), .first_i(first_i),
      .blk_ready_o(nc_blk_ready), .abort_i(abort_i), .load_o(nc_load), .iv_sel_o(nc_iv_sel),
      .step_en_o(nc_step_en), .step_o(nc_step), .g_o(nc_g), .s_o(nc_s), .fsel_o(nc_fsel),
      .ff_add_o(nc_ff_add), .hash_valid_o(nc_hash_valid), .hash_ready_i(hash_ready_i)
`ifdef MD5_STALL_EN
      , .dp_ready_i(dp_ready_i)
`endif
   );

   function automatic int exp_g(input int k);
      int i;
      i = k % 16;
      case (k / 16)
         0: return i;
         1: return (5 * i + 1) % 16;
         2: return (3 * i + 5) % 16;
         default: return (7 * i) % 16;
      endcase
   endfunction

   function automatic int exp_s(input int k);
      int s_tab[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
      return s_tab[(k / 16) * 4 + (k % 4)];
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic accept(input logic f);
      blk_valid_i = 1'b1;
      first_i     = f;
      tick();
      blk_valid_i = 1'b0;
   endtask

   task automatic run_until_valid(output int n);
      n = 0;
      while (hash_valid_o !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      #12;
      vectors++;
      if ({blk_ready_o, load_o, iv_sel_o, step_en_o, ff_add_o, hash_valid_o} !== 6'b101000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b expected 101000",
                  {blk_ready_o, load_o, iv_sel_o, step_en_o, ff_add_o, hash_valid_o});
      end
      vectors++;
      if (step_o !== 6'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_step: got %0d expected 0", step_o);
      end
      rst_i = 1'b1;
      tick();
   endtask

   task automatic test_single_block();
      int bad_k;
      bad_k = -1;
      accept(1'b1);
      vectors++;
      if ({load_o, iv_sel_o, blk_ready_o, step_en_o} !== 4'b1100) begin
         miscompares++;
         $display("[TB] FAIL load_cycle: got %b expected 1100", {load_o, iv_sel_o, blk_ready_o, step_en_o});
      end
      for (int k = 0; k < 64; k++) begin
         tick();
         vectors++;
         if (step_en_o !== 1'b1 || step_o !== 6'(k) || g_o !== 4'(exp_g(k)) ||
             s_o !== 5'(exp_s(k)) || fsel_o !== 2'(k / 16) || ff_add_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL run_step%0d: got en=%b step=%0d g=%0d s=%0d f=%0d ff=%b expected en=1 step=%0d g=%0d s=%0d f=%0d ff=0",
                     k, step_en_o, step_o, g_o, s_o, fsel_o, ff_add_o, k, exp_g(k), exp_s(k), k / 16);
         end
      end
      tick();
      vectors++;
      if ({ff_add_o, step_en_o, hash_valid_o} !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL ff_cycle: got %b expected 100", {ff_add_o, step_en_o, hash_valid_o});
      end
      tick();
      vectors++;
      if ({hash_valid_o, ff_add_o} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL done_cycle: got %b expected 10", {hash_valid_o, ff_add_o});
      end
      hash_ready_i = 1'b1;
      tick();
      hash_ready_i = 1'b0;
      vectors++;
      if ({hash_valid_o, blk_ready_o} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL back_to_idle: got %b expected 01", {hash_valid_o, blk_ready_o});
      end
   endtask

   task automatic test_decode();
      int n;
      accept(1'b1);
      tick();
      vectors++;
      if ({g_o, s_o, fsel_o} !== {4'd0, 5'd7, 2'd0}) begin
         miscompares++;
         $display("[TB] FAIL decode_step0: got g=%0d s=%0d f=%0d expected g=0 s=7 f=0", g_o, s_o, fsel_o);
      end
      repeat (17) tick();
      vectors++;
      if ({g_o, s_o, fsel_o} !== {4'd6, 5'd9, 2'd1}) begin
         miscompares++;
         $display("[TB] FAIL decode_step17: got g=%0d s=%0d f=%0d expected g=6 s=9 f=1", g_o, s_o, fsel_o);
      end
      repeat (18) tick();
      vectors++;
      if ({g_o, s_o, fsel_o} !== {4'd14, 5'd23, 2'd2}) begin
         miscompares++;
         $display("[TB] FAIL decode_step35: got g=%0d s=%0d f=%0d expected g=14 s=23 f=2", g_o, s_o, fsel_o);
      end
      repeat (28) tick();
      vectors++;
      if ({g_o, s_o, fsel_o} !== {4'd9, 5'd21, 2'd3}) begin
         miscompares++;
         $display("[TB] FAIL decode_step63: got g=%0d s=%0d f=%0d expected g=9 s=21 f=3", g_o, s_o, fsel_o);
      end
      run_until_valid(n);
      vectors++;
      if (n !== 2) begin
         miscompares++;
         $display("[TB] FAIL decode_tail: got %0d cycles expected 2", n);
      end
      hash_ready_i = 1'b1;
      tick();
      hash_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      accept(1'b1);
      run_until_valid(n);
      vectors++;
      if (n !== 66) begin
         miscompares++;
         $display("[TB] FAIL b2b_latency1: got %0d cycles expected 66", n);
      end
      blk_valid_i = 1'b1;
      first_i     = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if ({hash_valid_o, blk_ready_o, load_o} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold%0d: got %b expected 100", c, {hash_valid_o, blk_ready_o, load_o});
         end
         tick();
      end
      hash_ready_i = 1'b1;
      vectors++;
      if (hash_valid_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_hold_end: got %b expected 1", hash_valid_o);
      end
      tick();
      hash_ready_i = 1'b0;
      vectors++;
      if ({hash_valid_o, blk_ready_o, load_o} !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL b2b_no_bypass: got %b expected 010", {hash_valid_o, blk_ready_o, load_o});
      end
      tick();
      blk_valid_i = 1'b0;
      vectors++;
      if ({load_o, iv_sel_o, nc_load, nc_iv_sel} !== 4'b1011) begin
         miscompares++;
         $display("[TB] FAIL b2b_chain_sel: got %b expected 1011", {load_o, iv_sel_o, nc_load, nc_iv_sel});
      end
      run_until_valid(n);
      vectors++;
      if (n !== 66) begin
         miscompares++;
         $display("[TB] FAIL b2b_latency2: got %0d cycles expected 66", n);
      end
      hash_ready_i = 1'b1;
      tick();
      hash_ready_i = 1'b0;
   endtask

   task automatic test_abort();
      int n;
      logic seen;
      accept(1'b1);
      repeat (31) tick();
      vectors++;
      if (step_o !== 6'd30) begin
         miscompares++;
         $display("[TB] FAIL abort_at30: got step %0d expected 30", step_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      vectors++;
      if ({blk_ready_o, step_en_o, ff_add_o} !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL abort_run_idle: got %b expected 100", {blk_ready_o, step_en_o, ff_add_o});
      end
      seen = 1'b0;
      repeat (70) begin
         tick();
         if (ff_add_o === 1'b1 || hash_valid_o === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_ff: got %b expected 0", seen);
      end
      abort_i = 1'b1;
      accept(1'b1);
      abort_i = 1'b0;
      vectors++;
      if (load_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_idle_ignored: got %b expected 1", load_o);
      end
      repeat (65) tick();
      vectors++;
      if (ff_add_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_reach_ff: got %b expected 1", ff_add_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      vectors++;
      if ({hash_valid_o, blk_ready_o} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL abort_ff_idle: got %b expected 01", {hash_valid_o, blk_ready_o});
      end
      accept(1'b1);
      run_until_valid(n);
      vectors++;
      if (n !== 66) begin
         miscompares++;
         $display("[TB] FAIL abort_done_latency: got %0d expected 66", n);
      end
      abort_i      = 1'b1;
      hash_ready_i = 1'b1;
      tick();
      abort_i      = 1'b0;
      hash_ready_i = 1'b0;
      vectors++;
      if ({hash_valid_o, blk_ready_o} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL abort_done_drop: got %b expected 01", {hash_valid_o, blk_ready_o});
      end
   endtask

   task automatic test_async_reset();
      int n;
      accept(1'b0);
      repeat (41) tick();
      vectors++;
      if (step_o !== 6'd40) begin
         miscompares++;
         $display("[TB] FAIL rst_at40: got step %0d expected 40", step_o);
      end
      #2 rst_i = 1'b0;
      #1;
      vectors++;
      if ({blk_ready_o, load_o, iv_sel_o, step_en_o, ff_add_o, hash_valid_o, step_o} !== {6'b101000, 6'd0}) begin
         miscompares++;
         $display("[TB] FAIL rst_async: got %b/%0d expected 101000/0",
                  {blk_ready_o, load_o, iv_sel_o, step_en_o, ff_add_o, hash_valid_o}, step_o);
      end
      #2 rst_i = 1'b1;
      accept(1'b0);
      vectors++;
      if ({load_o, iv_sel_o, nc_iv_sel} !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL rst_reload: got %b expected 101", {load_o, iv_sel_o, nc_iv_sel});
      end
      tick();
      vectors++;
      if ({step_en_o, step_o} !== {1'b1, 6'd0}) begin
         miscompares++;
         $display("[TB] FAIL rst_restart: got en=%b step=%0d expected en=1 step=0", step_en_o, step_o);
      end
      run_until_valid(n);
      vectors++;
      if (n !== 65) begin
         miscompares++;
         $display("[TB] FAIL rst_complete: got %0d expected 65", n);
      end
      hash_ready_i = 1'b1;
      tick();
      hash_ready_i = 1'b0;
   endtask

`ifdef MD5_STALL_EN
   task automatic test_stall();
      int n;
      accept(1'b1);
      repeat (11) tick();
      for (int rep = 0; rep < 2; rep++) begin
         dp_ready_i = 1'b0;
         for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({step_en_o, step_o} !== {1'b0, 6'(10 + rep)}) begin
               miscompares++;
               $display("[TB] FAIL stall%0d_c%0d: got en=%b step=%0d expected en=0 step=%0d",
                        rep, c, step_en_o, step_o, 10 + rep);
            end
            tick();
         end
         dp_ready_i = 1'b1;
         if (rep == 0) tick();
      end
      run_until_valid(n);
      vectors++;
      if (n !== 54) begin
         miscompares++;
         $display("[TB] FAIL stall_latency: got %0d expected 54", n);
      end
      hash_ready_i = 1'b1;
      tick();
      hash_ready_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_block();
      test_decode();
      test_back_to_back();
      test_abort();
      test_async_reset();
`ifdef MD5_STALL_EN
      test_stall();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
